// File: rtl/etapa_decodificacion.sv
// RV32I decode stage (OP, OP-IMM, LUI) with a one-entry valid/ready output register.
// Optional handoff counters are enabled by defining DECOD_CONTADORES_EN.
module etapa_decodificacion (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruccion,
  input  logic        valido_in,
  output logic        listo_in,
  input  logic        flush,
  output logic        valido_out,
  input  logic        listo_out,
  output logic [3:0]  operacion,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] inmediato,
  output logic        usa_inmediato,
  output logic        escribe_reg,
  output logic        ilegal
`ifdef DECOD_CONTADORES_EN
  ,
  output logic [31:0] cont_instr,
  output logic [15:0] cont_ilegal
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [2:0]  funct3_p0;
  logic [6:0]  funct7_p0;
  logic [3:0]  op_p0;
  logic [4:0]  rs1_p0, rs2_p0, rd_p0;
  logic [31:0] imm_p0;
  logic        usa_imm_p0, escribe_p0, ilegal_p0;
  logic        carga;

  // Stage p0: combinational decode of the incoming word
  always_comb begin
    funct3_p0  = instruccion[14:12];
    funct7_p0  = instruccion[31:25];
    rs1_p0     = instruccion[19:15];
    rs2_p0     = instruccion[24:20];
    rd_p0      = instruccion[11:7];
    op_p0      = 4'b0000;
    imm_p0     = 32'd0;
    usa_imm_p0 = 1'b0;
    ilegal_p0  = 1'b1;
    case (instruccion[6:0])
      OPC_OP: begin
        if (funct7_p0 == 7'b0000000 ||
            (funct7_p0 == 7'b0100000 && (funct3_p0 == 3'b000 || funct3_p0 == 3'b101))) begin
          ilegal_p0 = 1'b0;
          op_p0     = {funct7_p0[5], funct3_p0};
        end
      end
      OPC_OP_IMM: begin
        case (funct3_p0)
          3'b001: begin
            if (funct7_p0 == 7'b0000000) begin
              ilegal_p0 = 1'b0;
              op_p0     = 4'b0001;
              imm_p0    = {27'd0, instruccion[24:20]};
            end
          end
          3'b101: begin
            if (funct7_p0 == 7'b0000000 || funct7_p0 == 7'b0100000) begin
              ilegal_p0 = 1'b0;
              op_p0     = {instruccion[30], 3'b101};
              imm_p0    = {27'd0, instruccion[24:20]};
            end
          end
          default: begin
            ilegal_p0 = 1'b0;
            op_p0     = {1'b0, funct3_p0};
            imm_p0    = {{20{instruccion[31]}}, instruccion[31:20]};
          end
        endcase
        // rs2 only reads as zero when the immediate form is actually accepted
        if (!ilegal_p0) begin
          usa_imm_p0 = 1'b1;
          rs2_p0     = 5'd0;
        end
      end
      OPC_LUI: begin
        ilegal_p0  = 1'b0;
        rs1_p0     = 5'd0;
        rs2_p0     = 5'd0;
        usa_imm_p0 = 1'b1;
        imm_p0     = {instruccion[31:12], 12'h000};
      end
      default: ;
    endcase
    escribe_p0 = !ilegal_p0 && (rd_p0 != 5'd0);
  end

  assign listo_in = !rst && (!valido_out || listo_out || flush);
  assign carga    = valido_in && listo_in;

  // Stage p1: output register; flush drops the entry but leaves data untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valido_out    <= 1'b0;
      operacion     <= 4'b0000;
      rs1           <= 5'd0;
      rs2           <= 5'd0;
      rd            <= 5'd0;
      inmediato     <= 32'd0;
      usa_inmediato <= 1'b0;
      escribe_reg   <= 1'b0;
      ilegal        <= 1'b0;
    end else begin
      if (flush)          valido_out <= 1'b0;
      else if (carga)     valido_out <= 1'b1;
      else if (listo_out) valido_out <= 1'b0;
      if (carga && !flush) begin
        operacion     <= op_p0;
        rs1           <= rs1_p0;
        rs2           <= rs2_p0;
        rd            <= rd_p0;
        inmediato     <= imm_p0;
        usa_inmediato <= usa_imm_p0;
        escribe_reg   <= escribe_p0;
        ilegal        <= ilegal_p0;
      end
    end
  end

`ifdef DECOD_CONTADORES_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_instr  <= 32'd0;
      cont_ilegal <= 16'd0;
    end else if (valido_out && listo_out) begin
      cont_instr <= cont_instr + 32'd1;
      if (ilegal) cont_ilegal <= cont_ilegal + 16'd1;
    end
  end
`endif

endmodule

// File: doc/etapa_decodificacion.md
ETAPA_DECODIFICACION -- requirements
Module: etapa_decodificacion

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 The ports SHALL be, one per line, as follows:
  clk            in   1   clock
  rst            in   1   asynchronous reset, active-high
  instruccion    in   32  RV32I instruction word
  valido_in      in   1   instruccion valid
  listo_in       out  1   block can accept instruccion this cycle
  flush          in   1   discard held and incoming instruction
  valido_out     out  1   decoded fields valid
  listo_out      in   1   downstream accepts decoded fields
  operacion      out  4   ALU op code: add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, sra 1101
  rs1, rs2, rd   out  5   register indices
  inmediato      out  32  decoded immediate
  usa_inmediato  out  1   ALU valB from inmediato, not rs2
  escribe_reg    out  1   write rd with ALU result
  ilegal         out  1   instruction not supported

Function
REQ-003 A handoff in SHALL occur when valido_in && listo_in; a handoff out SHALL occur when valido_out && listo_out.
REQ-004 listo_in SHALL equal !valido_out || listo_out || flush, which is combinational.
REQ-005 Decoded fields SHALL be registered and SHALL appear with valido_out=1 on the cycle after a handoff in, giving a latency of 1.
REQ-006 While valido_out=1 && listo_out=0 && flush=0, all outputs SHALL hold their values.
REQ-007 After a handoff out with no handoff in in the same cycle, valido_out SHALL go to 0. A simultaneous handoff out and handoff in SHALL load the new instruction, so full throughput is 1 instruction per cycle.
REQ-008 Opcode 0110011 (OP) SHALL decode as follows:
  - operacion={funct7[5],funct3}
  - usa_inmediato=0
  - legal only for funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
REQ-009 Opcode 0010011 (OP-IMM) SHALL decode as follows:
  - usa_inmediato=1; rs2=0
  - funct3=101: operacion={instr[30],101}; inmediato=zero-extended shamt instr[24:20]
  - funct3=001: operacion=0001; inmediato=zero-extended shamt instr[24:20]
  - all other funct3: operacion={0,funct3}; inmediato=sign-extended instr[31:20]
  - illegal if funct3=001 with instr[31:25]!=0, or funct3=101 with instr[31:25] not in {0000000,0100000}.
REQ-010 Opcode 0110111 (LUI) SHALL decode as follows:
  - operacion=0000, rs1=0, rs2=0, usa_inmediato=1
  - inmediato={instr[31:12],12'h000}.
REQ-011 Any other opcode, or any illegal case above, SHALL give:
  - ilegal=1, escribe_reg=0, operacion=0000, usa_inmediato=0, inmediato=0
  - rs1, rs2 and rd still extracted raw from instr[19:15], [24:20] and [11:7].
REQ-012 escribe_reg SHALL be 1 only for a legal instruction with rd!=0.
REQ-013 flush=1 SHALL clear valido_out on the next edge, with priority over listo_out and valido_in; an instruction presented during flush SHALL be consumed and discarded.
REQ-014 Data outputs SHALL change only on a load, so flush SHALL leave them unchanged.

Reset
REQ-015 When rst is asserted, every output register SHALL go to 0 immediately, independent of clk; this includes valido_out, operacion, rs1, rs2, rd, inmediato, usa_inmediato, escribe_reg and ilegal.
REQ-016 While rst=1, no handoff in SHALL be accepted. Release SHALL take effect at the first rising clk edge with rst=0.
REQ-017 Reset during a stall SHALL drop the held instruction.

Configuration
REQ-018 With the macro DECOD_CONTADORES_EN defined, the block SHALL add these outputs:
  - cont_instr (32 bits): increments on each handoff out
  - cont_ilegal (16 bits): increments on each handoff out with ilegal=1
REQ-019 Both counters SHALL wrap at full scale, reset to 0, and be unaffected by flush.
REQ-020 Without DECOD_CONTADORES_EN, these ports and registers SHALL be absent, with no other behavioural change.

Verification
REQ-021 Send 0x002081B3 (add x3,x1,x2) with listo_out=1 -> next cycle: valido_out=1, operacion=0000, rs1=1, rs2=2, rd=3, usa_inmediato=0, escribe_reg=1, ilegal=0.
REQ-022 Send 0x40335293 (srai x5,x6,3) -> operacion=1101, rs1=6, rd=5, inmediato=0x00000003, usa_inmediato=1.
REQ-023 Send 0xFFF00093 (addi x1,x0,-1) then 0x123453B7 (lui x7,0x12345) back to back -> outputs, on consecutive cycles:
  - inmediato=0xFFFFFFFF, then inmediato=0x12345000 with rs1=0, rd=7, operacion=0000.
REQ-024 Hold listo_out=0 with valido_out=1 for 3 cycles while valido_in=1 -> listo_in=0 and outputs stable. Then release -> next instruction appears 1 cycle later, with none lost or duplicated.
REQ-025 Send 0x00000000 -> ilegal=1, escribe_reg=0. With DECOD_CONTADORES_EN, cont_ilegal goes from 0 to 1 after the handoff out.
REQ-026 Pulse flush with valido_out=1 and listo_out=0 -> valido_out=0 the next cycle. Separately, assert rst mid-stall -> all outputs 0 with no clk edge.
